// File: rtl/seg_scan_if.sv
// Scanned 7-segment bus as seen by the loop-back decoder, plus the reassembled frame it reports.
// The display driver owns AN/SEGMENT; the decoder owns everything else.
interface seg_scan_if;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] num;
    logic [3:0]  point;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        seg_err;

    modport master (
        output AN, SEGMENT,
        input  num, point, blank, frame_valid, seg_err
    );

    modport slave (
        input  AN, SEGMENT,
        output num, point, blank, frame_valid, seg_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Loop-back monitor for a multiplexed 7-segment display: filters each digit slot for stability,
// decodes it back to a hex nibble and reassembles the 16-bit value, decimal points and blanking.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

    logic [3:0]    an_r;
    logic [7:0]    seg_r;
    logic [CW-1:0] cnt;
    logic          same;
    logic          capture;

    logic [3:0]  dec_nib;
    logic        dec_legal;
    logic        dec_blank;

    logic [3:0]  sel;
    logic        one_hot;
    logic        idle;
    logic        slot_ok;
    logic        slot_err;
    logic        frame_done;

    logic [15:0] nib_s, nib_nxt;
    logic [3:0]  pt_s, pt_nxt;
    logic [3:0]  bl_s, bl_nxt;
    logic [3:0]  mask;

    assign same    = ({bus.AN, bus.SEGMENT} == {an_r, seg_r});
    // The counter saturates one past the capture value, so a long hold captures only once.
    assign capture = same && (cnt == CNT_CAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= 4'hF;
            seg_r <= 8'hFF;
            cnt   <= '0;
        end else begin
            an_r  <= bus.AN;
            seg_r <= bus.SEGMENT;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        dec_nib   = 4'h0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (seg_r[6:0])
            7'h40: dec_nib = 4'h0;
            7'h79: dec_nib = 4'h1;
            7'h24: dec_nib = 4'h2;
            7'h30: dec_nib = 4'h3;
            7'h19: dec_nib = 4'h4;
            7'h12: dec_nib = 4'h5;
            7'h02: dec_nib = 4'h6;
            7'h78: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h10: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h03: dec_nib = 4'hB;
            7'h46: dec_nib = 4'hC;
            7'h21: dec_nib = 4'hD;
            7'h06: dec_nib = 4'hE;
            7'h0E: dec_nib = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    assign sel        = ~an_r;
    assign one_hot    = $onehot(sel);
    assign idle       = (an_r == 4'hF);
    assign slot_ok    = capture && one_hot && dec_legal;
    assign slot_err   = capture && !idle && !(one_hot && dec_legal);
    assign frame_done = slot_ok && ((mask | sel) == 4'hF);

    // Staging with the current slot merged in, so the completing digit reaches num on the same edge.
    always_comb begin
        nib_nxt = nib_s;
        pt_nxt  = pt_s;
        bl_nxt  = bl_s;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                nib_nxt[4*i +: 4] = dec_nib;
                pt_nxt[i]         = ~seg_r[7];
                bl_nxt[i]         = dec_blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nib_s           <= '0;
            pt_s            <= '0;
            bl_s            <= '0;
            mask            <= '0;
            bus.num         <= '0;
            bus.point       <= '0;
            bus.blank       <= '0;
            bus.frame_valid <= 1'b0;
            bus.seg_err     <= 1'b0;
        end else begin
            bus.frame_valid <= frame_done;
            bus.seg_err     <= slot_err;
            if (slot_ok) begin
                nib_s <= nib_nxt;
                pt_s  <= pt_nxt;
                bl_s  <= bl_nxt;
                mask  <= frame_done ? 4'h0 : (mask | sel);
            end
            if (frame_done) begin
                bus.num   <= nib_nxt;
                bus.point <= pt_nxt;
                bus.blank <= bl_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with STABLE_CYCLES=4.
module tb_seg_scan_decoder;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   fv_cnt;
    int   err_cnt;

    seg_scan_if bus();

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_valid) fv_cnt++;
            if (bus.seg_err)     err_cnt++;
        end
    end

    // Enter just after a rising edge; the pins are registered on the next n edges.
    task automatic hold(input logic [3:0] an, input logic [7:0] seg, input int n);
        bus.AN      = an;
        bus.SEGMENT = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.AN      = 4'hF;
        bus.SEGMENT = 8'hFF;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        fv_cnt  = 0;
        err_cnt = 0;
        @(negedge clk);
        total++; if (bus.num !== 16'h0000) begin bad++; $display("FAIL reset_num got=%h exp=0000", bus.num); end
        total++; if (bus.point !== 4'h0) begin bad++; $display("FAIL reset_point got=%b exp=0000", bus.point); end
        total++; if (bus.blank !== 4'h0) begin bad++; $display("FAIL reset_blank got=%b exp=0000", bus.blank); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
        total++; if (bus.seg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.seg_err); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_scan();
        fv_cnt = 0;
        hold(4'b1110, 8'h99, 8);
        hold(4'b1101, 8'hB0, 8);
        hold(4'b1011, 8'hA4, 8);
        bus.AN      = 4'b0111;
        bus.SEGMENT = 8'hF9;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_early got=%b exp=0", bus.frame_valid); end
        @(posedge clk);
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv_pulse got=%b exp=1", bus.frame_valid); end
        total++; if (bus.num !== 16'h1234) begin bad++; $display("FAIL basic_num got=%h exp=1234", bus.num); end
        total++; if (bus.point !== 4'h0) begin bad++; $display("FAIL basic_point got=%b exp=0000", bus.point); end
        total++; if (bus.blank !== 4'h0) begin bad++; $display("FAIL basic_blank got=%b exp=0000", bus.blank); end
        repeat (3) @(posedge clk);
        #1;
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL basic_fv_count got=%0d exp=1", fv_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL basic_err_count got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_hold_boundary();
        fv_cnt = 0;
        hold(4'b1110, 8'h92, 8);
        hold(4'b1101, 8'h82, 8);
        hold(4'b1011, 8'hF8, 8);
        hold(4'b0111, 8'h80, 4);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 0) begin bad++; $display("FAIL hold4_no_capture fv_count got=%0d exp=0", fv_cnt); end
        bus.AN      = 4'b0111;
        bus.SEGMENT = 8'h80;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL hold5_fv_early got=%b exp=0", bus.frame_valid); end
        @(posedge clk);
        #1;
        bus.AN      = 4'hF;
        bus.SEGMENT = 8'hFF;
        @(negedge clk);
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL hold5_fv got=%b exp=1", bus.frame_valid); end
        total++; if (bus.num !== 16'h8765) begin bad++; $display("FAIL hold5_num got=%h exp=8765", bus.num); end
        @(posedge clk);
        #1;
        hold(4'hF, 8'hFF, 8);
    endtask

    task automatic test_blank_dp();
        fv_cnt = 0;
        hold(4'b1110, 8'hC6, 8);
        hold(4'b1101, 8'h83, 8);
        hold(4'b1011, 8'h7F, 8);
        hold(4'b0111, 8'h88, 8);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL blank_fv_count got=%0d exp=1", fv_cnt); end
        total++; if (bus.num !== 16'hA0BC) begin bad++; $display("FAIL blank_num got=%h exp=a0bc", bus.num); end
        total++; if (bus.blank !== 4'b0100) begin bad++; $display("FAIL blank_blank got=%b exp=0100", bus.blank); end
        total++; if (bus.point !== 4'b0100) begin bad++; $display("FAIL blank_point got=%b exp=0100", bus.point); end
    endtask

    task automatic test_bad_pattern();
        fv_cnt  = 0;
        err_cnt = 0;
        hold(4'b1101, 8'hD5, 8);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL badpat_err_count got=%0d exp=1", err_cnt); end
        hold(4'b1110, 8'h90, 8);
        hold(4'b1011, 8'h86, 8);
        hold(4'b0111, 8'h8E, 8);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 0) begin bad++; $display("FAIL badpat_no_mask fv_count got=%0d exp=0", fv_cnt); end
        hold(4'b1101, 8'hA1, 8);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL badpat_recover fv_count got=%0d exp=1", fv_cnt); end
        total++; if (bus.num !== 16'hFED9) begin bad++; $display("FAIL badpat_num got=%h exp=fed9", bus.num); end
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL badpat_err_final got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_bad_an();
        fv_cnt  = 0;
        err_cnt = 0;
        hold(4'b0011, 8'hC0, 8);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL badan_err_count got=%0d exp=1", err_cnt); end
        hold(4'hF, 8'hC0, 8);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL idle_err_count got=%0d exp=1", err_cnt); end
        total++; if (fv_cnt !== 0) begin bad++; $display("FAIL idle_fv_count got=%0d exp=0", fv_cnt); end
        total++; if (bus.num !== 16'hFED9) begin bad++; $display("FAIL idle_num got=%h exp=fed9", bus.num); end
    endtask

    task automatic test_reset_midframe();
        hold(4'b1110, 8'hF9, 8);
        hold(4'b1101, 8'hA4, 8);
        hold(4'b1011, 8'hB0, 8);
        bus.AN      = 4'hF;
        bus.SEGMENT = 8'hFF;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        fv_cnt  = 0;
        err_cnt = 0;
        total++; if (bus.num !== 16'h0000) begin bad++; $display("FAIL rstmid_num_cleared got=%h exp=0000", bus.num); end
        hold(4'b0111, 8'hF8, 8);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 0) begin bad++; $display("FAIL rstmid_no_frame fv_count got=%0d exp=0", fv_cnt); end
        total++; if (bus.num !== 16'h0000) begin bad++; $display("FAIL rstmid_num got=%h exp=0000", bus.num); end
        hold(4'b1110, 8'h99, 8);
        hold(4'b1101, 8'h92, 8);
        hold(4'b1011, 8'h82, 8);
        hold(4'b0111, 8'hF8, 8);
        hold(4'hF, 8'hFF, 8);
        total++; if (fv_cnt !== 1) begin bad++; $display("FAIL rstmid_rescan fv_count got=%0d exp=1", fv_cnt); end
        total++; if (bus.num !== 16'h7654) begin bad++; $display("FAIL rstmid_rescan_num got=%h exp=7654", bus.num); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        fv_cnt      = 0;
        err_cnt     = 0;
        rst         = 1'b1;
        bus.AN      = 4'hF;
        bus.SEGMENT = 8'hFF;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_scan();
        test_hold_boundary();
        test_blank_dp();
        test_bad_pattern();
        test_bad_an();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
